multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RISC datapath. It steps the cycle counter Cnt through fetch, decode, execute, memory and writeback, and decodes the latched instruction fields. It generates every datapath strobe, including ALUorNot and the end-of-instruction Buff_PC pulse. It stalls on a memory ready handshake and halts on HLT or a bus timeout.

---
 rtl/isa_pkg.sv | 77 +++++++
 rtl/multicycle_decode.sv | 167 ++++++++++++++++
 rtl/multicycle_ctrl.sv | 118 +++++++++++
 tb/tb_multicycle_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA encodings for the multicycle RISC control path: opcodes, condition
// codes, datapath select encodings, FSM states and instruction classification.
package isa_pkg;

  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] OP_LHI   = 5'b00001;
  localparam logic [4:0] OP_LLI   = 5'b00010;
  localparam logic [4:0] OP_LDRI  = 5'b00011;
  localparam logic [4:0] OP_LDRR  = 5'b00100;
  localparam logic [4:0] OP_STRI  = 5'b00101;
  localparam logic [4:0] OP_STRR  = 5'b00110;
  localparam logic [4:0] OP_ADDI  = 5'b00111;
  localparam logic [4:0] OP_SUBI  = 5'b01000;
  localparam logic [4:0] OP_MOV   = 5'b01011;
  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_JALRL = 5'b10001;
  localparam logic [4:0] OP_JALRR = 5'b10010;
  localparam logic [4:0] OP_JR    = 5'b10011;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_BAL   = 5'b11001;
  localparam logic [4:0] OP_SYS   = 5'b11100;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_CS = 3'b010;
  localparam logic [2:0] COND_CC = 3'b011;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_PASSB, ALU_LHI, ALU_LLI
  } alu_op_t;

  typedef enum logic [1:0] {PC_REL, PC_REG, PC_ALU} pc_sel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC, WB_IMM} wb_sel_t;

  typedef enum logic {RUN, HALT} state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_MOV, CL_IMM, CL_CMP, CL_LOAD, CL_STORE, CL_BR, CL_BAL,
    CL_JMP, CL_JALRL, CL_JALRR, CL_JR, CL_OUT, CL_HLT, CL_ILL
  } iclass_t;

  function automatic iclass_t classify(input logic [4:0] op, input logic [1:0] fn);
    iclass_t c;
    case (op)
      OP_ALU, OP_ADDI, OP_SUBI: c = CL_ALU;
      OP_MOV:                   c = CL_MOV;
      OP_LHI, OP_LLI:           c = CL_IMM;
      OP_LDRI:                  c = CL_LOAD;
      OP_LDRR:                  c = (fn == 2'b00) ? CL_LOAD : CL_ILL;
      OP_STRI:                  c = CL_STORE;
      // STRrr and CMP share an opcode, split by the function bits
      OP_STRR:                  c = (fn == 2'b00) ? CL_STORE :
                                    (fn == 2'b01) ? CL_CMP : CL_ILL;
      OP_JMP:                   c = CL_JMP;
      OP_JALRL:                 c = CL_JALRL;
      OP_JALRR:                 c = CL_JALRR;
      OP_JR:                    c = CL_JR;
      OP_BR:                    c = CL_BR;
      OP_BAL:                   c = CL_BAL;
      OP_SYS:                   c = (fn == 2'b00) ? CL_OUT :
                                    (fn == 2'b01) ? CL_HLT : CL_ILL;
      default:                  c = CL_ILL;
    endcase
    return c;
  endfunction

  function automatic logic cond_taken(input logic [2:0] cond, input logic c, input logic z);
    case (cond)
      COND_NE: return !z;
      COND_EQ: return z;
      COND_CS: return c;
      COND_CC: return !c;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Combinational step decoder: maps the latched instruction, flags and step
// counter to datapath strobes, the last-step marker and memory-step status.
module multicycle_decode
  import isa_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [4:0]       op,
  input  logic [2:0]       cond,
  input  logic [1:0]       fn,
  input  logic             flag_c,
  input  logic             flag_z,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             mem_re,
  output logic             mem_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             link_we,
  output logic             alu_or_not,
  output logic [2:0]       alu_op,
  output logic             flag_we,
  output logic             out_we,
  output logic             last,
  output logic             illegal,
  output logic             halt_req,
  output logic             mem_step
);

  iclass_t cls;
  alu_op_t alu_reg_op;

  always_comb begin
    cls = classify(op, fn);
    if (op == OP_ALU)       alu_reg_op = alu_op_t'({1'b0, fn});
    else if (op == OP_SUBI) alu_reg_op = ALU_SUB;
    else                    alu_reg_op = ALU_ADD;
  end

  always_comb begin
    ir_load    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_sel     = PC_REL;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    link_we    = 1'b0;
    alu_or_not = 1'b0;
    alu_op     = ALU_ADD;
    flag_we    = 1'b0;
    out_we     = 1'b0;
    last       = 1'b0;
    illegal    = 1'b0;
    halt_req   = 1'b0;
    mem_step   = 1'b0;
    if (en) begin
      case (cnt)
        CNT_W'(0): begin
          mem_re   = 1'b1;
          mem_step = 1'b1;
          ir_load  = mem_ready;
          pc_inc   = mem_ready;
        end
        CNT_W'(1): begin
          if (cls == CL_ILL) begin
            illegal = 1'b1;
            last    = 1'b1;
          end
        end
        CNT_W'(2): begin
          case (cls)
            CL_ALU: begin
              alu_or_not = 1'b1;
              alu_op     = alu_reg_op;
              flag_we    = 1'b1;
            end
            CL_MOV: begin
              alu_or_not = 1'b1;
              alu_op     = ALU_PASSB;
            end
            CL_IMM: begin
              alu_or_not = 1'b1;
              alu_op     = (op == OP_LHI) ? ALU_LHI : ALU_LLI;
              reg_we     = 1'b1;
              last       = 1'b1;
            end
            CL_CMP: begin
              alu_or_not = 1'b1;
              alu_op     = ALU_SUB;
              flag_we    = 1'b1;
              last       = 1'b1;
            end
            CL_LOAD, CL_STORE: alu_or_not = 1'b1;
            CL_BR: begin
              pc_load = cond_taken(cond, flag_c, flag_z);
              last    = 1'b1;
            end
            CL_BAL, CL_JMP: begin
              pc_load = 1'b1;
              last    = 1'b1;
            end
            CL_JALRL: begin
              pc_load = 1'b1;
              link_we = 1'b1;
              wb_sel  = WB_PC;
              last    = 1'b1;
            end
            CL_JALRR: begin
              pc_load = 1'b1;
              pc_sel  = PC_REG;
              link_we = 1'b1;
              wb_sel  = WB_PC;
              last    = 1'b1;
            end
            CL_JR: begin
              pc_load = 1'b1;
              pc_sel  = PC_REG;
              last    = 1'b1;
            end
            CL_OUT: begin
              out_we = 1'b1;
              last   = 1'b1;
            end
            CL_HLT:  halt_req = 1'b1;
            default: ;
          endcase
        end
        CNT_W'(3): begin
          case (cls)
            CL_ALU, CL_MOV: begin
              alu_or_not = 1'b1;
              alu_op     = (cls == CL_MOV) ? ALU_PASSB : alu_reg_op;
              reg_we     = 1'b1;
              last       = 1'b1;
            end
            CL_LOAD: begin
              mem_re   = 1'b1;
              mem_step = 1'b1;
            end
            CL_STORE: begin
              mem_we   = 1'b1;
              mem_step = 1'b1;
              last     = mem_ready;
            end
            default: ;
          endcase
        end
        CNT_W'(4): begin
          if (cls == CL_LOAD) begin
            reg_we = 1'b1;
            wb_sel = WB_MEM;
            last   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle datapath: step counter, memory stall
// timeout and halt handling around the combinational step decoder.
module multicycle_ctrl
  import isa_pkg::*;
#(
  parameter int STALL_LIMIT = 15,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ir_m,
  input  logic [1:0]       ir_l,
  input  logic             flag_c,
  input  logic             flag_z,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] cnt,
  output logic             ir_load,
  output logic             mem_re,
  output logic             mem_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             link_we,
  output logic             alu_or_not,
  output logic [2:0]       alu_op,
  output logic             flag_we,
  output logic             out_we,
  output logic             buff_pc,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [SW-1:0]    stall_cnt;
  logic             bus_err_q;
  logic             en, halt_req, mem_step, stalled, stall_hit;

  // rst_n gates the decoder so every strobe drops the instant reset asserts
  assign en = rst_n && (state == RUN);

  multicycle_decode #(.CNT_W(CNT_W)) u_decode (
    .en         (en),
    .cnt        (cnt_q),
    .op         (ir_m[7:3]),
    .cond       (ir_m[2:0]),
    .fn         (ir_l),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .mem_ready  (mem_ready),
    .ir_load    (ir_load),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_sel     (pc_sel),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .link_we    (link_we),
    .alu_or_not (alu_or_not),
    .alu_op     (alu_op),
    .flag_we    (flag_we),
    .out_we     (out_we),
    .last       (buff_pc),
    .illegal    (illegal),
    .halt_req   (halt_req),
    .mem_step   (mem_step)
  );

  assign stalled   = mem_step && !mem_ready;
  assign stall_hit = stalled && (stall_cnt == SW'(STALL_LIMIT - 1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    if (state == RUN) begin
      if (halt_req || stall_hit) begin
        state_next = HALT;
        cnt_next   = '0;
      end else if (cnt_q > CNT_W'(4)) begin
        cnt_next = '0;
      end else if (stalled) begin
        cnt_next = cnt_q;
      end else if (buff_pc) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_q + 1'b1;
      end
    end else begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt_q     <= '0;
      stall_cnt <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt_q <= cnt_next;
      if (state == RUN && stalled && !stall_hit) stall_cnt <= stall_cnt + 1'b1;
      else                                       stall_cnt <= '0;
      if (stall_hit) bus_err_q <= 1'b1;
    end
  end

  assign cnt     = cnt_q;
  assign halted  = (state == HALT);
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instructions step by step and
// compares counter, strobes and status against hand-computed values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir_m;
  logic [1:0] ir_l;
  logic       flag_c, flag_z, mem_ready;
  logic [2:0] cnt;
  logic       ir_load, mem_re, mem_we, pc_inc, pc_load, reg_we, link_we;
  logic       alu_or_not, flag_we, out_we, buff_pc, halted, illegal, bus_err;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] alu_op;

  int checks = 0;
  int errors = 0;

  // strobe vector bit positions
  localparam logic [11:0] IRL = 12'h800, MRE = 12'h400, MWE = 12'h200, PCI = 12'h100;
  localparam logic [11:0] PCL = 12'h080, RWE = 12'h040, LNK = 12'h020, ALU = 12'h010;
  localparam logic [11:0] FWE = 12'h008, OWE = 12'h004, BUF = 12'h002, ILL = 12'h001;
  localparam logic [11:0] FETCH = IRL | MRE | PCI;

  logic [11:0] strb;
  assign strb = {ir_load, mem_re, mem_we, pc_inc, pc_load, reg_we, link_we,
                 alu_or_not, flag_we, out_we, buff_pc, illegal};

  multicycle_ctrl #(.STALL_LIMIT(15), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ir_m(ir_m), .ir_l(ir_l), .flag_c(flag_c),
    .flag_z(flag_z), .mem_ready(mem_ready), .cnt(cnt), .ir_load(ir_load),
    .mem_re(mem_re), .mem_we(mem_we), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel), .link_we(link_we),
    .alu_or_not(alu_or_not), .alu_op(alu_op), .flag_we(flag_we),
    .out_we(out_we), .buff_pc(buff_pc), .halted(halted), .illegal(illegal),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_chk(input string tag, input int exp_cnt, input logic [11:0] exp_s);
    chk({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    chk({tag, "_strb"}, 32'(strb), 32'(exp_s));
  endtask

  // advance one clock, land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ir_m = '0; ir_l = '0; flag_c = 1'b0; flag_z = 1'b0; mem_ready = 1'b1;
    #2;
    step_chk("reset", 0, '0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_buserr", 32'(bus_err), 0);
    #10 rst_n = 1'b1;
    #1;
    step_chk("add_f", 0, FETCH);

    // ADD
    tick(); step_chk("add_s1", 1, '0);
    tick(); step_chk("add_s2", 2, ALU | FWE);
    chk("add_s2_op", 32'(alu_op), 0);
    tick(); step_chk("add_s3", 3, ALU | RWE | BUF);
    chk("add_s3_wb", 32'(wb_sel), 0);

    // SBB: function bits select the carry-subtract op
    tick(); ir_l = 2'b11; #1; step_chk("sbb_f", 0, FETCH);
    tick(); tick(); step_chk("sbb_s2", 2, ALU | FWE);
    chk("sbb_s2_op", 32'(alu_op), 3);
    tick();

    // LDRri with two stalled cycles at the memory step
    tick(); ir_m = 8'b00011_000; ir_l = 2'b00; #1; step_chk("ldr_f", 0, FETCH);
    tick(); step_chk("ldr_s1", 1, '0);
    tick(); step_chk("ldr_s2", 2, ALU);
    tick(); mem_ready = 1'b0; #1; step_chk("ldr_s3a", 3, MRE);
    tick(); step_chk("ldr_s3b", 3, MRE);
    tick(); mem_ready = 1'b1; #1; step_chk("ldr_s3c", 3, MRE);
    tick(); step_chk("ldr_s4", 4, RWE | BUF);
    chk("ldr_s4_wb", 32'(wb_sel), 1);

    // BEQ taken
    tick(); ir_m = 8'b11000_001; flag_z = 1'b1; #1; step_chk("beq1_f", 0, FETCH);
    tick(); tick(); step_chk("beq1_s2", 2, PCL | BUF);
    chk("beq1_sel", 32'(pc_sel), 0);
    // BEQ not taken
    tick(); flag_z = 1'b0; #1;
    tick(); tick(); step_chk("beq0_s2", 2, BUF);

    // STRri, store completes on the ready cycle
    tick(); ir_m = 8'b00101_000; #1;
    tick(); tick(); step_chk("str_s2", 2, ALU);
    tick(); mem_ready = 1'b0; #1; step_chk("str_s3a", 3, MWE);
    mem_ready = 1'b1; #1; step_chk("str_s3b", 3, MWE | BUF);

    // JALrl
    tick(); ir_m = 8'b10001_000; #1;
    tick(); tick(); step_chk("jal_s2", 2, PCL | LNK | BUF);
    chk("jal_wb", 32'(wb_sel), 2);

    // Illegal opcode 01111
    tick(); ir_m = 8'b01111_000; #1;
    tick(); step_chk("ill_s1", 1, ILL | BUF);
    tick(); step_chk("ill_next", 0, FETCH);

    // Reset asserted during a fetch stall
    mem_ready = 1'b0;
    tick(); tick(); tick(); step_chk("stall_f", 0, MRE);
    rst_n = 1'b0; #1;
    step_chk("midrst", 0, '0);
    rst_n = 1'b1; mem_ready = 1'b1; #1;

    // HLT
    ir_m = 8'b11100_000; ir_l = 2'b01; #1;
    tick(); tick(); step_chk("hlt_s2", 2, '0);
    chk("hlt_s2_halted", 32'(halted), 0);
    tick(); chk("hlt_halted", 32'(halted), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hlt_idle", 32'({halted, cnt, strb}), 32'({1'b1, 3'd0, 12'd0}));
    end
    rst_n = 1'b0; #1;
    chk("hlt_rst", 32'(halted), 0);

    // Fetch timeout after 15 stalled cycles
    ir_l = 2'b00; ir_m = '0; mem_ready = 1'b0;
    rst_n = 1'b1;
    repeat (14) tick();
    chk("to14_buserr", 32'({bus_err, halted}), 32'(2'b00));
    step_chk("to14", 0, MRE);
    tick();
    chk("to15_buserr", 32'({bus_err, halted}), 32'(2'b11));
    step_chk("to15", 0, '0);
    mem_ready = 1'b1;
    tick(); chk("to_sticky", 32'(bus_err), 1);
    rst_n = 1'b0; #1;
    chk("to_rst", 32'({bus_err, halted}), 0);
    step_chk("to_rst", 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
